axi_ram_rd_arb: RTL and testbench

AXI_RAM_RD_ARB -- requirements
Module: axi_ram_rd_arb

---
 rtl/axi_ram_rd_arb_if.sv | 82 ++++++++
 rtl/axi_ram_rd_arb.sv | 176 +++++++++++++++++
 tb/tb_axi_ram_rd_arb.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_rd_arb_if.sv
// Bus bundle for the two-requester RAM read arbiter: two requester-side
// command/response channels, one RAM-side channel, and a debug view of the FSM.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where the producer's valid/en and the consumer's ready are both high.
// Payload fields are meaningful only while valid/en is high.
interface axi_ram_rd_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   s0_rd_cmd_id;
  logic [ADDR_WIDTH-1:0] s0_rd_cmd_addr;
  logic                  s0_rd_cmd_en;
  logic                  s0_rd_cmd_last;
  logic                  s0_rd_cmd_ready;
  logic [ID_WIDTH-1:0]   s0_rd_resp_id;
  logic [DATA_WIDTH-1:0] s0_rd_resp_data;
  logic                  s0_rd_resp_last;
  logic                  s0_rd_resp_valid;
  logic                  s0_rd_resp_ready;

  logic [ID_WIDTH-1:0]   s1_rd_cmd_id;
  logic [ADDR_WIDTH-1:0] s1_rd_cmd_addr;
  logic                  s1_rd_cmd_en;
  logic                  s1_rd_cmd_last;
  logic                  s1_rd_cmd_ready;
  logic [ID_WIDTH-1:0]   s1_rd_resp_id;
  logic [DATA_WIDTH-1:0] s1_rd_resp_data;
  logic                  s1_rd_resp_last;
  logic                  s1_rd_resp_valid;
  logic                  s1_rd_resp_ready;

  logic [ID_WIDTH-1:0]   m_rd_cmd_id;
  logic [ADDR_WIDTH-1:0] m_rd_cmd_addr;
  logic                  m_rd_cmd_en;
  logic                  m_rd_cmd_last;
  logic                  m_rd_cmd_ready;
  logic [ID_WIDTH-1:0]   m_rd_resp_id;
  logic [DATA_WIDTH-1:0] m_rd_resp_data;
  logic                  m_rd_resp_last;
  logic                  m_rd_resp_valid;
  logic                  m_rd_resp_ready;

  // FSM observation: 0 = IDLE, 1 = GRANT0, 2 = GRANT1; plus priority pointer.
  logic [1:0]            dbg_state;
  logic                  dbg_prio;

  // Arbiter side.
  modport slave (
    input  s0_rd_cmd_id, s0_rd_cmd_addr, s0_rd_cmd_en, s0_rd_cmd_last,
    output s0_rd_cmd_ready,
    output s0_rd_resp_id, s0_rd_resp_data, s0_rd_resp_last, s0_rd_resp_valid,
    input  s0_rd_resp_ready,
    input  s1_rd_cmd_id, s1_rd_cmd_addr, s1_rd_cmd_en, s1_rd_cmd_last,
    output s1_rd_cmd_ready,
    output s1_rd_resp_id, s1_rd_resp_data, s1_rd_resp_last, s1_rd_resp_valid,
    input  s1_rd_resp_ready,
    output m_rd_cmd_id, m_rd_cmd_addr, m_rd_cmd_en, m_rd_cmd_last,
    input  m_rd_cmd_ready,
    input  m_rd_resp_id, m_rd_resp_data, m_rd_resp_last, m_rd_resp_valid,
    output m_rd_resp_ready,
    output dbg_state, dbg_prio
  );

  // Environment side (requesters + RAM).
  modport master (
    output s0_rd_cmd_id, s0_rd_cmd_addr, s0_rd_cmd_en, s0_rd_cmd_last,
    input  s0_rd_cmd_ready,
    input  s0_rd_resp_id, s0_rd_resp_data, s0_rd_resp_last, s0_rd_resp_valid,
    output s0_rd_resp_ready,
    output s1_rd_cmd_id, s1_rd_cmd_addr, s1_rd_cmd_en, s1_rd_cmd_last,
    input  s1_rd_cmd_ready,
    input  s1_rd_resp_id, s1_rd_resp_data, s1_rd_resp_last, s1_rd_resp_valid,
    output s1_rd_resp_ready,
    input  m_rd_cmd_id, m_rd_cmd_addr, m_rd_cmd_en, m_rd_cmd_last,
    output m_rd_cmd_ready,
    output m_rd_resp_id, m_rd_resp_data, m_rd_resp_last, m_rd_resp_valid,
    input  m_rd_resp_ready,
    input  dbg_state, dbg_prio
  );
endinterface

// File: rtl/axi_ram_rd_arb.sv
// Two-requester read arbiter in front of a single RAM read port.
// A grant is held for a whole burst (until an accepted last beat), with
// round-robin priority between bursts. Each forwarded beat records its source
// in a small routing FIFO so in-order responses go back to the right requester.
module axi_ram_rd_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  axi_ram_rd_arb_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               src_mem [FIFO_DEPTH];

  logic                  fifo_full, fifo_empty, head;
  logic                  push, pop, grant_src;
  logic                  cmd_en, cmd_last, s0_cmd_ready, s1_cmd_ready;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  resp_ready;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = src_mem[rd_ptr_q];
  assign grant_src  = (state_q == ST_GRANT1);
  assign push       = cmd_en && bus.m_rd_cmd_ready;
  assign pop        = bus.m_rd_resp_valid && resp_ready;

  // State, priority and FIFO bookkeeping registers; reset acts without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next grant: arbitrate only from IDLE, release only on an accepted last beat.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.s0_rd_cmd_en && bus.s1_rd_cmd_en)
          state_d = prio_q ? ST_GRANT1 : ST_GRANT0;
        else if (bus.s0_rd_cmd_en)
          state_d = ST_GRANT0;
        else if (bus.s1_rd_cmd_en)
          state_d = ST_GRANT1;
      end
      ST_GRANT0: begin
        if (push && cmd_last) begin
          state_d = ST_IDLE;
          prio_d  = 1'b1;
        end
      end
      ST_GRANT1: begin
        if (push && cmd_last) begin
          state_d = ST_IDLE;
          prio_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command path: pass the granted requester through, gated by FIFO space.
  always_comb begin
    cmd_en       = 1'b0;
    cmd_last     = 1'b0;
    cmd_id       = '0;
    cmd_addr     = '0;
    s0_cmd_ready = 1'b0;
    s1_cmd_ready = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        cmd_en       = bus.s0_rd_cmd_en && !fifo_full;
        cmd_last     = bus.s0_rd_cmd_last;
        cmd_id       = bus.s0_rd_cmd_id;
        cmd_addr     = bus.s0_rd_cmd_addr;
        s0_cmd_ready = bus.m_rd_cmd_ready && !fifo_full;
      end
      ST_GRANT1: begin
        cmd_en       = bus.s1_rd_cmd_en && !fifo_full;
        cmd_last     = bus.s1_rd_cmd_last;
        cmd_id       = bus.s1_rd_cmd_id;
        cmd_addr     = bus.s1_rd_cmd_addr;
        s1_cmd_ready = bus.m_rd_cmd_ready && !fifo_full;
      end
      default: ;
    endcase
  end

  assign bus.m_rd_cmd_en     = cmd_en;
  assign bus.m_rd_cmd_last   = cmd_last;
  assign bus.m_rd_cmd_id     = cmd_id;
  assign bus.m_rd_cmd_addr   = cmd_addr;
  assign bus.s0_rd_cmd_ready = s0_cmd_ready;
  assign bus.s1_rd_cmd_ready = s1_cmd_ready;

  // Response path: steer the RAM response to the FIFO head's requester only.
  always_comb begin
    resp_ready           = 1'b0;
    bus.s0_rd_resp_valid = 1'b0;
    bus.s0_rd_resp_id    = '0;
    bus.s0_rd_resp_data  = '0;
    bus.s0_rd_resp_last  = 1'b0;
    bus.s1_rd_resp_valid = 1'b0;
    bus.s1_rd_resp_id    = '0;
    bus.s1_rd_resp_data  = '0;
    bus.s1_rd_resp_last  = 1'b0;
    if (!fifo_empty) begin
      if (head) begin
        resp_ready           = bus.s1_rd_resp_ready;
        bus.s1_rd_resp_valid = bus.m_rd_resp_valid;
        bus.s1_rd_resp_id    = bus.m_rd_resp_id;
        bus.s1_rd_resp_data  = bus.m_rd_resp_data;
        bus.s1_rd_resp_last  = bus.m_rd_resp_last;
      end else begin
        resp_ready           = bus.s0_rd_resp_ready;
        bus.s0_rd_resp_valid = bus.m_rd_resp_valid;
        bus.s0_rd_resp_id    = bus.m_rd_resp_id;
        bus.s0_rd_resp_data  = bus.m_rd_resp_data;
        bus.s0_rd_resp_last  = bus.m_rd_resp_last;
      end
    end
  end

  assign bus.m_rd_resp_ready = resp_ready;

  // Routing FIFO pointer/count update; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Routing FIFO storage; entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) src_mem[wr_ptr_q] <= grant_src;
  end

  assign bus.dbg_state = state_q;
  assign bus.dbg_prio  = prio_q;

endmodule

// File: tb/tb_axi_ram_rd_arb.sv
// Directed bench for axi_ram_rd_arb: arbitration order, burst grant hold,
// routing FIFO back-pressure, response steering and asynchronous reset.
module tb_axi_ram_rd_arb;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int DEPTH = 4;
  localparam logic [IW-1:0] ID0 = 8'h11;
  localparam logic [IW-1:0] ID1 = 8'h22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int route_q[$];
  int acc_q[$];
  int tag = 0;

  axi_ram_rd_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_ram_rd_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s0_rd_cmd_id = '0; bus.s0_rd_cmd_addr = '0; bus.s0_rd_cmd_en = 1'b0;
    bus.s0_rd_cmd_last = 1'b0; bus.s0_rd_resp_ready = 1'b0;
    bus.s1_rd_cmd_id = '0; bus.s1_rd_cmd_addr = '0; bus.s1_rd_cmd_en = 1'b0;
    bus.s1_rd_cmd_last = 1'b0; bus.s1_rd_resp_ready = 1'b0;
    bus.m_rd_cmd_ready = 1'b0;
    bus.m_rd_resp_id = '0; bus.m_rd_resp_data = '0;
    bus.m_rd_resp_last = 1'b0; bus.m_rd_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    route_q.delete();
    acc_q.delete();
  endtask

  // Returns n responses to requester dest and checks the steering of each.
  task automatic drain_resp(input int n, input int dest);
    bus.s0_rd_resp_ready = 1'b1;
    bus.s1_rd_resp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.m_rd_resp_valid = 1'b1;
      bus.m_rd_resp_id = dest ? ID1 : ID0;
      bus.m_rd_resp_data = 32'hE000_0000 + DW'(i);
      bus.m_rd_resp_last = (i == n - 1);
      #1;
      checks++;
      if ((dest ? bus.s1_rd_resp_valid : bus.s0_rd_resp_valid) !== 1'b1 ||
          (dest ? bus.s0_rd_resp_valid : bus.s1_rd_resp_valid) !== 1'b0) begin
        errors++;
        $display("FAIL drain_valid dest=%0d s0v=%b s1v=%b", dest,
                 bus.s0_rd_resp_valid, bus.s1_rd_resp_valid);
      end
      checks++;
      if ((dest ? bus.s1_rd_resp_data : bus.s0_rd_resp_data) !== 32'hE000_0000 + DW'(i)) begin
        errors++;
        $display("FAIL drain_data got %h exp %h", dest ? bus.s1_rd_resp_data : bus.s0_rd_resp_data,
                 32'hE000_0000 + DW'(i));
      end
      checks++;
      if (bus.m_rd_resp_ready !== 1'b1) begin
        errors++;
        $display("FAIL drain_ready got %b exp 1", bus.m_rd_resp_ready);
      end
      step();
    end
    bus.m_rd_resp_valid = 1'b0;
    #1;
    checks++;
    if (bus.m_rd_resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty_ready got %b exp 0", bus.m_rd_resp_ready);
    end
  endtask

  // Drives both requesters (len0/len1 beats, bursts of blen), optionally
  // answering every forwarded beat one cycle later with a tagged response.
  task automatic run_cmds(input int len0, input int len1, input int blen,
                          input bit auto_resp, input int budget, output int cmd_cyc);
    int b0 = 0;
    int b1 = 0;
    int cyc = 0;
    int src, dst;
    bit resp_sent;
    logic [DW-1:0] d;
    logic [AW-1:0] exp_addr;
    cmd_cyc = -1;
    while (((b0 < len0) || (b1 < len1) || (auto_resp && route_q.size() > 0)) && cyc < budget) begin
      bus.s0_rd_cmd_en = (b0 < len0);
      bus.s0_rd_cmd_addr = AW'(4 * b0);
      bus.s0_rd_cmd_last = ((b0 % blen) == blen - 1);
      bus.s0_rd_cmd_id = ID0;
      bus.s1_rd_cmd_en = (b1 < len1);
      bus.s1_rd_cmd_addr = AW'(16'h0100 + 4 * b1);
      bus.s1_rd_cmd_last = ((b1 % blen) == blen - 1);
      bus.s1_rd_cmd_id = ID1;
      resp_sent = 1'b0;
      if (auto_resp && route_q.size() > 0) begin
        bus.m_rd_resp_valid = 1'b1;
        bus.m_rd_resp_data = exp_q[0];
        bus.m_rd_resp_id = route_q[0] ? ID1 : ID0;
        resp_sent = 1'b1;
      end else begin
        bus.m_rd_resp_valid = 1'b0;
      end
      #1;
      if (resp_sent) begin
        dst = route_q.pop_front();
        d = exp_q.pop_front();
        checks++;
        if ((dst ? bus.s1_rd_resp_valid : bus.s0_rd_resp_valid) !== 1'b1 ||
            (dst ? bus.s0_rd_resp_valid : bus.s1_rd_resp_valid) !== 1'b0 ||
            (dst ? bus.s1_rd_resp_data : bus.s0_rd_resp_data) !== d) begin
          errors++;
          $display("FAIL run_resp dest=%0d s0v=%b s1v=%b s0d=%h s1d=%h exp %h", dst,
                   bus.s0_rd_resp_valid, bus.s1_rd_resp_valid,
                   bus.s0_rd_resp_data, bus.s1_rd_resp_data, d);
        end
      end
      if (bus.m_rd_cmd_en && bus.m_rd_cmd_ready) begin
        checks++;
        if (!({bus.s0_rd_cmd_ready, bus.s1_rd_cmd_ready} == 2'b10 ||
              {bus.s0_rd_cmd_ready, bus.s1_rd_cmd_ready} == 2'b01)) begin
          errors++;
          $display("FAIL run_onehot_ready s0r=%b s1r=%b exp exactly one",
                   bus.s0_rd_cmd_ready, bus.s1_rd_cmd_ready);
        end
        src = bus.s1_rd_cmd_ready ? 1 : 0;
        exp_addr = src ? AW'(16'h0100 + 4 * b1) : AW'(4 * b0);
        checks++;
        if (bus.m_rd_cmd_addr !== exp_addr || bus.m_rd_cmd_id !== (src ? ID1 : ID0)) begin
          errors++;
          $display("FAIL run_cmd_fwd addr=%h id=%h exp addr=%h id=%h", bus.m_rd_cmd_addr,
                   bus.m_rd_cmd_id, exp_addr, src ? ID1 : ID0);
        end
        acc_q.push_back(src);
        if (auto_resp) begin
          route_q.push_back(src);
          exp_q.push_back(32'hD000_0000 + DW'(tag));
          tag++;
        end
        if (src == 1) b1++; else b0++;
        if (b0 >= len0 && b1 >= len1) cmd_cyc = cyc + 1;
      end
      step();
      cyc++;
    end
    bus.s0_rd_cmd_en = 1'b0;
    bus.s1_rd_cmd_en = 1'b0;
    bus.m_rd_resp_valid = 1'b0;
    checks++;
    if (cyc >= budget) begin
      errors++;
      $display("FAIL run_timeout cycles %0d budget %0d b0=%0d b1=%0d", cyc, budget, b0, b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.s0_rd_cmd_en = 1'b1; bus.s1_rd_cmd_en = 1'b1; bus.m_rd_cmd_ready = 1'b1;
    bus.m_rd_resp_valid = 1'b1; bus.s0_rd_resp_ready = 1'b1; bus.s1_rd_resp_ready = 1'b1;
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.dbg_state !== 2'd0 || bus.dbg_prio !== 1'b0) begin
        errors++;
        $display("FAIL reset_state state=%0d prio=%b exp 0 0", bus.dbg_state, bus.dbg_prio);
      end
      checks++;
      if ({bus.m_rd_cmd_en, bus.s0_rd_cmd_ready, bus.s1_rd_cmd_ready} !== 3'b000) begin
        errors++;
        $display("FAIL reset_cmd en/r0/r1=%b%b%b exp 000", bus.m_rd_cmd_en,
                 bus.s0_rd_cmd_ready, bus.s1_rd_cmd_ready);
      end
      checks++;
      if ({bus.m_rd_resp_ready, bus.s0_rd_resp_valid, bus.s1_rd_resp_valid} !== 3'b000) begin
        errors++;
        $display("FAIL reset_resp ready/v0/v1=%b%b%b exp 000", bus.m_rd_resp_ready,
                 bus.s0_rd_resp_valid, bus.s1_rd_resp_valid);
      end
      step();
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_burst();
    do_reset();
    bus.m_rd_cmd_ready = 1'b1;
    bus.s0_rd_cmd_en = 1'b1; bus.s0_rd_cmd_id = ID0;
    bus.s0_rd_cmd_addr = '0; bus.s0_rd_cmd_last = 1'b0;
    #1;
    checks++;
    if (bus.m_rd_cmd_en !== 1'b0 || bus.m_rd_cmd_addr !== '0) begin
      errors++;
      $display("FAIL burst_bubble en=%b addr=%h exp 0 0", bus.m_rd_cmd_en, bus.m_rd_cmd_addr);
    end
    step();
    for (int b = 0; b < 3; b++) begin
      bus.s0_rd_cmd_addr = AW'(4 * b);
      bus.s0_rd_cmd_last = (b == 2);
      #1;
      checks++;
      if ({bus.m_rd_cmd_en, bus.s0_rd_cmd_ready, bus.s1_rd_cmd_ready} !== 3'b110) begin
        errors++;
        $display("FAIL burst_beat%0d en/r0/r1=%b%b%b exp 110", b, bus.m_rd_cmd_en,
                 bus.s0_rd_cmd_ready, bus.s1_rd_cmd_ready);
      end
      checks++;
      if (bus.m_rd_cmd_addr !== AW'(4 * b) || bus.m_rd_cmd_last !== (b == 2) ||
          bus.m_rd_cmd_id !== ID0) begin
        errors++;
        $display("FAIL burst_fwd%0d addr=%h last=%b id=%h exp %h %b %h", b, bus.m_rd_cmd_addr,
                 bus.m_rd_cmd_last, bus.m_rd_cmd_id, AW'(4 * b), (b == 2), ID0);
      end
      step();
    end
    bus.s0_rd_cmd_en = 1'b0;
    #1;
    checks++;
    if (bus.dbg_state !== 2'd0 || bus.dbg_prio !== 1'b1 || bus.m_rd_cmd_en !== 1'b0) begin
      errors++;
      $display("FAIL burst_end state=%0d prio=%b en=%b exp 0 1 0", bus.dbg_state,
               bus.dbg_prio, bus.m_rd_cmd_en);
    end
    drain_resp(3, 0);
  endtask

  task automatic test_arb_order();
    int cc;
    int exp_order[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    do_reset();
    bus.m_rd_cmd_ready = 1'b1;
    bus.s0_rd_resp_ready = 1'b1;
    bus.s1_rd_resp_ready = 1'b1;
    run_cmds(4, 4, 2, 1'b1, 60, cc);
    checks++;
    if (acc_q.size() != 8) begin
      errors++;
      $display("FAIL order_count got %0d exp 8", acc_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (acc_q[i] != exp_order[i]) begin
          errors++;
          $display("FAIL order_beat%0d got s%0d exp s%0d", i, acc_q[i], exp_order[i]);
        end
      end
    end
    checks++;
    if (cc != 12) begin
      errors++;
      $display("FAIL order_cycles got %0d exp 12", cc);
    end
    checks++;
    if (bus.dbg_prio !== 1'b0 || bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL order_end prio=%b state=%0d exp 0 0", bus.dbg_prio, bus.dbg_state);
    end
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    int b = 0;
    do_reset();
    bus.m_rd_cmd_ready = 1'b1;
    bus.s1_rd_cmd_en = 1'b1; bus.s1_rd_cmd_id = ID1;
    bus.s1_rd_cmd_addr = 16'h0100; bus.s1_rd_cmd_last = 1'b0;
    step();
    for (int c = 0; c < 8; c++) begin
      bus.s1_rd_cmd_addr = AW'(16'h0100 + 4 * b);
      bus.s1_rd_cmd_last = (b == 7);
      #1;
      if (bus.m_rd_cmd_en && bus.m_rd_cmd_ready) begin
        acc++;
        b++;
      end
      step();
    end
    bus.s1_rd_cmd_addr = AW'(16'h0100 + 4 * b);
    #1;
    checks++;
    if (acc != DEPTH) begin
      errors++;
      $display("FAIL full_accepted got %0d exp %0d", acc, DEPTH);
    end
    checks++;
    if (bus.m_rd_cmd_en !== 1'b0 || bus.s1_rd_cmd_ready !== 1'b0 || bus.dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL full_stall en=%b r1=%b state=%0d exp 0 0 2", bus.m_rd_cmd_en,
               bus.s1_rd_cmd_ready, bus.dbg_state);
    end
    bus.s1_rd_cmd_en = 1'b0;
    bus.s1_rd_resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.m_rd_resp_valid = 1'b1;
      bus.m_rd_resp_id = ID1;
      bus.m_rd_resp_data = 32'h0000_00B0 + DW'(i);
      #1;
      checks++;
      if (bus.s1_rd_resp_valid !== 1'b1 || bus.s0_rd_resp_valid !== 1'b0 ||
          bus.s1_rd_resp_data !== 32'h0000_00B0 + DW'(i) || bus.m_rd_resp_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_release%0d v1=%b v0=%b d1=%h ready=%b exp 1 0 %h 1", i,
                 bus.s1_rd_resp_valid, bus.s0_rd_resp_valid, bus.s1_rd_resp_data,
                 bus.m_rd_resp_ready, 32'h0000_00B0 + DW'(i));
      end
      step();
    end
    bus.m_rd_resp_valid = 1'b0;
    bus.s1_rd_cmd_en = 1'b1;
    for (int k = 4; k < 8; k++) begin
      bus.s1_rd_cmd_addr = AW'(16'h0100 + 4 * k);
      bus.s1_rd_cmd_last = (k == 7);
      #1;
      checks++;
      if (bus.m_rd_cmd_en !== 1'b1 || bus.m_rd_cmd_addr !== AW'(16'h0100 + 4 * k)) begin
        errors++;
        $display("FAIL full_resume%0d en=%b addr=%h exp 1 %h", k, bus.m_rd_cmd_en,
                 bus.m_rd_cmd_addr, AW'(16'h0100 + 4 * k));
      end
      step();
    end
    bus.s1_rd_cmd_en = 1'b0;
    #1;
    checks++;
    if (bus.dbg_state !== 2'd0 || bus.dbg_prio !== 1'b0) begin
      errors++;
      $display("FAIL full_end state=%0d prio=%b exp 0 0", bus.dbg_state, bus.dbg_prio);
    end
    drain_resp(4, 1);
  endtask

  task automatic test_interleave();
    int cc;
    do_reset();
    bus.m_rd_cmd_ready = 1'b1;
    run_cmds(2, 0, 2, 1'b0, 20, cc);
    run_cmds(0, 2, 2, 1'b0, 20, cc);
    checks++;
    if (acc_q.size() != 4) begin
      errors++;
      $display("FAIL inter_count got %0d exp 4", acc_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      bus.m_rd_resp_valid = 1'b1;
      bus.m_rd_resp_id = (i < 2) ? ID0 : ID1;
      bus.m_rd_resp_data = 32'h0000_00C0 + DW'(i);
      bus.m_rd_resp_last = (i % 2 == 1);
      // First hold the owning requester not-ready while the other is ready.
      bus.s0_rd_resp_ready = (i >= 2);
      bus.s1_rd_resp_ready = (i < 2);
      #1;
      checks++;
      if (bus.m_rd_resp_ready !== 1'b0) begin
        errors++;
        $display("FAIL inter_stall%0d ready=%b exp 0", i, bus.m_rd_resp_ready);
      end
      step();
      bus.s0_rd_resp_ready = (i < 2);
      bus.s1_rd_resp_ready = (i >= 2);
      #1;
      checks++;
      if (bus.m_rd_resp_ready !== 1'b1) begin
        errors++;
        $display("FAIL inter_ready%0d ready=%b exp 1", i, bus.m_rd_resp_ready);
      end
      checks++;
      if (i < 2) begin
        if (bus.s0_rd_resp_valid !== 1'b1 || bus.s1_rd_resp_valid !== 1'b0 ||
            bus.s0_rd_resp_id !== ID0 || bus.s0_rd_resp_data !== 32'h0000_00C0 + DW'(i) ||
            bus.s1_rd_resp_data !== '0) begin
          errors++;
          $display("FAIL inter_route%0d v0=%b v1=%b id0=%h d0=%h d1=%h exp to s0 only", i,
                   bus.s0_rd_resp_valid, bus.s1_rd_resp_valid, bus.s0_rd_resp_id,
                   bus.s0_rd_resp_data, bus.s1_rd_resp_data);
        end
      end else begin
        if (bus.s1_rd_resp_valid !== 1'b1 || bus.s0_rd_resp_valid !== 1'b0 ||
            bus.s1_rd_resp_id !== ID1 || bus.s1_rd_resp_data !== 32'h0000_00C0 + DW'(i) ||
            bus.s0_rd_resp_data !== '0) begin
          errors++;
          $display("FAIL inter_route%0d v0=%b v1=%b id1=%h d1=%h d0=%h exp to s1 only", i,
                   bus.s0_rd_resp_valid, bus.s1_rd_resp_valid, bus.s1_rd_resp_id,
                   bus.s1_rd_resp_data, bus.s0_rd_resp_data);
        end
      end
      step();
    end
    bus.m_rd_resp_valid = 1'b0;
    #1;
    checks++;
    if (bus.m_rd_resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL inter_empty ready=%b exp 0", bus.m_rd_resp_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cc;
    do_reset();
    bus.m_rd_cmd_ready = 1'b1;
    bus.s0_rd_resp_ready = 1'b1;
    bus.s1_rd_resp_ready = 1'b1;
    run_cmds(1, 0, 1, 1'b1, 20, cc);
    checks++;
    if (bus.dbg_prio !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_prio_before got %b exp 1", bus.dbg_prio);
    end
    bus.s0_rd_cmd_en = 1'b1; bus.s0_rd_cmd_id = ID0;
    bus.s0_rd_cmd_addr = '0; bus.s0_rd_cmd_last = 1'b0;
    step();
    step();
    bus.s0_rd_cmd_addr = 16'h0004;
    #1;
    checks++;
    if (bus.m_rd_cmd_en !== 1'b1 || bus.s0_rd_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_granted en=%b r0=%b exp 1 1", bus.m_rd_cmd_en, bus.s0_rd_cmd_ready);
    end
    #1;
    rst = 1'b1;
    bus.m_rd_resp_valid = 1'b1;
    #1;
    checks++;
    if ({bus.m_rd_cmd_en, bus.s0_rd_cmd_ready, bus.s1_rd_cmd_ready} !== 3'b000 ||
        bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_async en/r0/r1=%b%b%b state=%0d exp 000 0", bus.m_rd_cmd_en,
               bus.s0_rd_cmd_ready, bus.s1_rd_cmd_ready, bus.dbg_state);
    end
    checks++;
    if (bus.m_rd_resp_ready !== 1'b0 || bus.s0_rd_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_resp ready=%b v0=%b exp 0 0", bus.m_rd_resp_ready,
               bus.s0_rd_resp_valid);
    end
    step();
    rst = 1'b0;
    bus.s0_rd_cmd_en = 1'b0;
    bus.s1_rd_cmd_en = 1'b1; bus.s1_rd_cmd_id = ID1;
    bus.s1_rd_cmd_addr = 16'h0100; bus.s1_rd_cmd_last = 1'b1;
    #1;
    checks++;
    if (bus.m_rd_resp_ready !== 1'b0 || bus.s0_rd_resp_valid !== 1'b0 ||
        bus.s1_rd_resp_valid !== 1'b0 || bus.m_rd_cmd_en !== 1'b0 || bus.dbg_prio !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after ready=%b v0=%b v1=%b en=%b prio=%b exp 0 0 0 0 0",
               bus.m_rd_resp_ready, bus.s0_rd_resp_valid, bus.s1_rd_resp_valid,
               bus.m_rd_cmd_en, bus.dbg_prio);
    end
    bus.m_rd_resp_valid = 1'b0;
    step();
    #1;
    checks++;
    if (bus.dbg_state !== 2'd2 || bus.m_rd_cmd_en !== 1'b1 || bus.s1_rd_cmd_ready !== 1'b1 ||
        bus.m_rd_cmd_addr !== 16'h0100) begin
      errors++;
      $display("FAIL rstmid_regrant state=%0d en=%b r1=%b addr=%h exp 2 1 1 0100",
               bus.dbg_state, bus.m_rd_cmd_en, bus.s1_rd_cmd_ready, bus.m_rd_cmd_addr);
    end
    step();
    bus.s1_rd_cmd_en = 1'b0;
    drain_resp(1, 1);
  endtask

  // Test sequence and final report.
  initial begin
    idle_inputs();
    test_reset();
    test_single_burst();
    test_arb_order();
    test_fifo_full();
    test_interleave();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
